// File: rtl/fdiv_arb_pkg.sv
// Shared types for the two-requester fdiv arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional macro FDIV_ARB_EXC_EN widens each response entry with ovf/unf flags.
package fdiv_arb_pkg;

    localparam int N_REQ = 2;

    typedef logic req_id_t;

    // One slot of the in-flight tracking pipe: is there an op here, and whose.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

`ifdef FDIV_ARB_EXC_EN
    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } rsp_entry_t;
`else
    typedef struct packed {
        logic [31:0] y;
    } rsp_entry_t;
`endif

endpackage

// File: rtl/fdiv_arb_fifo.sv
// Small synchronous FIFO holding finished results for one requester.
// Latency: a write is visible on rd_valid the cycle after; no empty bypass.
// Backpressure: rd_valid/rd_ready pop; write and pop may share a cycle even when full.
// Ports: clk, rst (sync, active high), wr_en/wr_data (push), rd_valid/rd_ready/rd_data (pop).
module fdiv_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         do_wr;
    logic         do_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid = (wr_ptr != rd_ptr);
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign do_rd    = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot being written when full.
    assign do_wr    = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/fdiv_arbiter.sv
// Shares one pipelined fdiv between two requesters with round-robin issue and per-requester result FIFOs.
// Latency: accept to rspI_valid is LAT+2 cycles (registered issue, LAT divider cycles, FIFO write).
// Backpressure: per-requester credits (in flight + queued <= DEPTH) so the non-stallable divider never overruns a FIFO.
// Ports: sys_clk/rst (sync, active high); reqI_valid/ready/x1/x2 operand inputs; rspI_valid/ready/y results
//        (rspI_ovf/unf only with FDIV_ARB_EXC_EN); div_* connect to the fdiv unit; err_desync is a sticky tag mismatch.
// Optional macro FDIV_ARB_EXC_EN: carries div_ovf/div_unf through the FIFOs to rspI_ovf/rspI_unf.
module fdiv_arbiter
    import fdiv_arb_pkg::*;
#(
    parameter int LAT   = 6,
    parameter int DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_y,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_y,
`ifdef FDIV_ARB_EXC_EN
    output logic        rsp0_ovf,
    output logic        rsp0_unf,
    output logic        rsp1_ovf,
    output logic        rsp1_unf,
`endif

    output logic        div_valid,
    output logic [31:0] div_x1,
    output logic [31:0] div_x2,
    input  logic        div_out_valid,
    input  logic [31:0] div_y,
    input  logic        div_ovf,
    input  logic        div_unf,

    output logic        err_desync
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int MW = $clog2(LAT + 2);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [MW-1:0] MASK_INIT  = MW'(LAT + 1);
    localparam logic [MW-1:0] MASK_ONE   = MW'(1);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] credit;
    logic [N_REQ-1:0] accept;
    logic [N_REQ-1:0] rsp_valid;
    logic [N_REQ-1:0] rsp_ready;
    logic [N_REQ-1:0] pop;
    logic [N_REQ-1:0] wr_en;
    logic [CW-1:0]    cnt [N_REQ];

    req_id_t    rr_ptr;
    req_id_t    acc_id;
    logic       acc_any;
    req_id_t    div_id;
    tag_t       tag_pipe [LAT];
    tag_t       tap;
    logic [MW-1:0] mask_cnt;
    logic       masked;
    logic       result_ok;
    rsp_entry_t wr_entry;
    rsp_entry_t rd_entry [N_REQ];

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // ---------------------------------------------------------------
    // Credit-gated round-robin grant. Each ready looks only at the
    // other side's request, never its own, so the handshake has no
    // valid->ready combinational path. When a side is ready but idle,
    // the other may also be ready; only one of them can actually fire.
    // ---------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            credit[i] = (cnt[i] < CREDIT_MAX);
        end
    end

    assign req_ready[0] = !rst && credit[0] && (!rr_ptr || !(req_valid[1] && credit[1]));
    assign req_ready[1] = !rst && credit[1] && ( rr_ptr || !(req_valid[0] && credit[0]));
    assign req0_ready   = req_ready[0];
    assign req1_ready   = req_ready[1];

    assign accept  = req_valid & req_ready;
    assign acc_any = |accept;
    assign acc_id  = accept[1];
    assign pop     = rsp_valid & rsp_ready;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (acc_any) begin
            rr_ptr <= ~acc_id;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (!accept[i] && pop[i]) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Registered issue. Operands hold when idle to avoid toggling the
    // divider datapath.
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            div_valid <= 1'b0;
            div_id    <= 1'b0;
            div_x1    <= '0;
            div_x2    <= '0;
        end else begin
            div_valid <= acc_any;
            if (acc_any) begin
                div_id <= acc_id;
                div_x1 <= acc_id ? req1_x1 : req0_x1;
                div_x2 <= acc_id ? req1_x2 : req0_x2;
            end
        end
    end

    // ---------------------------------------------------------------
    // Tag pipe: stage 0 captures the op being presented to the divider,
    // so the last stage lines up with that op's div_out_valid.
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: div_valid, id: div_id};
            for (int k = 1; k < LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign tap = tag_pipe[LAT-1];

    // Results still draining out of the divider across a reset have no
    // tag; ignore div_out_valid until they have all emerged.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mask_cnt <= MASK_INIT;
        end else if (mask_cnt != '0) begin
            mask_cnt <= mask_cnt - MASK_ONE;
        end
    end

    assign masked    = (mask_cnt != '0);
    assign result_ok = !masked && div_out_valid && tap.valid;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            err_desync <= 1'b0;
        end else if (!masked && (div_out_valid != tap.valid)) begin
            err_desync <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Result steering into the owner's FIFO.
    // ---------------------------------------------------------------
    assign wr_en[0] = result_ok && !tap.id;
    assign wr_en[1] = result_ok &&  tap.id;

    always_comb begin
        wr_entry   = '0;
        wr_entry.y = div_y;
`ifdef FDIV_ARB_EXC_EN
        wr_entry.ovf = div_ovf;
        wr_entry.unf = div_unf;
`endif
    end

`ifndef FDIV_ARB_EXC_EN
    logic unused_flags;
    assign unused_flags = div_ovf | div_unf;
`endif

    for (genvar i = 0; i < N_REQ; i++) begin : g_rsp
        fdiv_arb_fifo #(
            .DEPTH (DEPTH),
            .W     ($bits(rsp_entry_t))
        ) u_fifo (
            .clk      (sys_clk),
            .rst      (rst),
            .wr_en    (wr_en[i]),
            .wr_data  (wr_entry),
            .rd_valid (rsp_valid[i]),
            .rd_ready (rsp_ready[i]),
            .rd_data  (rd_entry[i])
        );
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_y     = rd_entry[0].y;
    assign rsp1_y     = rd_entry[1].y;
`ifdef FDIV_ARB_EXC_EN
    assign rsp0_ovf   = rd_entry[0].ovf;
    assign rsp0_unf   = rd_entry[0].unf;
    assign rsp1_ovf   = rd_entry[1].ovf;
    assign rsp1_unf   = rd_entry[1].unf;
`endif

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Directed bench for fdiv_arbiter with a behavioural LAT-cycle divider stand-in.
// The stand-in divides exactly when the divisor mantissa is zero (power-of-two divisors).
module tb_fdiv_arbiter;

    localparam int LAT   = 6;
    localparam int DEPTH = 4;

    logic        sys_clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_y, rsp1_y;
`ifdef FDIV_ARB_EXC_EN
    logic        rsp0_ovf, rsp0_unf, rsp1_ovf, rsp1_unf;
`endif
    logic        div_valid;
    logic [31:0] div_x1, div_x2;
    logic        div_out_valid;
    logic [31:0] div_y;
    logic        div_ovf, div_unf;
    logic        err_desync;

    int n_cmp = 0;
    int n_err = 0;

    logic        hv [LAT+1];
    logic [31:0] hy [LAT+1];

    logic [31:0] t2a [3] = '{32'h40400000, 32'h40a00000, 32'h40e00000};
    logic [31:0] t2b [3] = '{32'h41000000, 32'h41100000, 32'h41300000};
    logic [31:0] e2a [3] = '{32'h3fc00000, 32'h40200000, 32'h40600000};
    logic [31:0] e2b [3] = '{32'h40800000, 32'h40900000, 32'h40b00000};
    logic [31:0] t3  [5] = '{32'h3f800000, 32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000};
    logic [31:0] t4  [7] = '{32'h40400000, 32'h40a00000, 32'h40e00000, 32'h41100000,
                             32'h41300000, 32'h41500000, 32'h41700000};

    fdiv_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_x1       (req0_x1),
        .req0_x2       (req0_x2),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_x1       (req1_x1),
        .req1_x2       (req1_x2),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp0_y        (rsp0_y),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp1_y        (rsp1_y),
`ifdef FDIV_ARB_EXC_EN
        .rsp0_ovf      (rsp0_ovf),
        .rsp0_unf      (rsp0_unf),
        .rsp1_ovf      (rsp1_ovf),
        .rsp1_unf      (rsp1_unf),
`endif
        .div_valid     (div_valid),
        .div_x1        (div_x1),
        .div_x2        (div_x2),
        .div_out_valid (div_out_valid),
        .div_y         (div_y),
        .div_ovf       (div_ovf),
        .div_unf       (div_unf),
        .err_desync    (err_desync)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] fdiv_model(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] e;
        e = a[30:23] - b[30:23] + 8'd127;
        return {a[31] ^ b[31], e, a[22:0]};
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one cycle; then feed the divider stand-in from the new div_valid.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        for (int k = LAT; k > 0; k--) begin
            hv[k] = hv[k-1];
            hy[k] = hy[k-1];
        end
        hv[0] = div_valid;
        hy[0] = fdiv_model(div_x1, div_x2);
        div_out_valid = hv[LAT];
        div_y         = hy[LAT];
    endtask

    int   c, idx, idx0, idx1, k0, k1, nacc;
    logic r, r0, r1, any_rsp, any_err;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_x1 = '0; req0_x2 = '0;
        req1_valid = 1'b0; req1_x1 = '0; req1_x2 = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        div_out_valid = 1'b0; div_y = '0; div_ovf = 1'b0; div_unf = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            hv[k] = 1'b0;
            hy[k] = '0;
        end

        // ---------------- reset state ----------------
        repeat (3) tick();
        check1 ("rst_div_valid",  div_valid,  1'b0);
        check32("rst_div_x1",     div_x1,     32'h0);
        check1 ("rst_req0_ready", req0_ready, 1'b0);
        check1 ("rst_rsp0_valid", rsp0_valid, 1'b0);
        check1 ("rst_rsp1_valid", rsp1_valid, 1'b0);
        check32("rst_rsp0_y",     rsp0_y,     32'h0);
        check1 ("rst_err",        err_desync, 1'b0);

        // ---------------- single op 10.0 / 4.0 ----------------
        rst = 1'b0;
        req0_valid = 1'b1; req0_x1 = 32'h41200000; req0_x2 = 32'h40800000;
        #1;
        check1("t1_ready", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        c = 1;
        check1 ("t1_div_valid", div_valid, 1'b1);
        check32("t1_div_x1",    div_x1,    32'h41200000);
        check32("t1_div_x2",    div_x2,    32'h40800000);
        tick(); c++;
        check1 ("t1_div_idle",  div_valid, 1'b0);
        check32("t1_div_hold",  div_x1,    32'h41200000);
        while (!rsp0_valid && c < 30) begin
            tick(); c++;
        end
        check32("t1_latency", c, 8);
        check32("t1_y",       rsp0_y, 32'h40200000);
        check1 ("t1_rsp1",    rsp1_valid, 1'b0);
        check1 ("t1_err",     err_desync, 1'b0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check1("t1_popped", rsp0_valid, 1'b0);

        // ---------------- both requesters every cycle ----------------
        // Pointer now favours req1 (req0 was granted last), so grants go 1,0,1,0,...
        idx0 = 0; idx1 = 0; k0 = 0; k1 = 0;
        req0_x2 = 32'h40000000; req1_x2 = 32'h40000000;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            req0_valid = (idx0 < 3);
            req1_valid = (idx1 < 3);
            req0_x1 = t2a[(idx0 < 3) ? idx0 : 2];
            req1_x1 = t2b[(idx1 < 3) ? idx1 : 2];
            #1;
            if (i < 6) begin
                check1("t2_grant0", req0_ready, (i % 2 == 1));
                check1("t2_grant1", req1_ready, (i % 2 == 0));
            end
            if (rsp0_valid && k0 < 3) begin
                check32("t2_y0", rsp0_y, e2a[k0]);
                k0++;
            end
            if (rsp1_valid && k1 < 3) begin
                check32("t2_y1", rsp1_y, e2b[k1]);
                k1++;
            end
            r0 = req0_valid && req0_ready;
            r1 = req1_valid && req1_ready;
            tick();
            if (r0) idx0++;
            if (r1) idx1++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check32("t2_count0", k0, 3);
        check32("t2_count1", k1, 3);
        check1 ("t2_err",    err_desync, 1'b0);

        // ---------------- req0 credit stall ----------------
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        idx = 0; nacc = 0;
        req0_x2 = 32'h3f800000;
        for (int i = 0; i < 14; i++) begin
            req0_valid = 1'b1;
            req0_x1 = t3[(idx < 5) ? idx : 4];
            #1;
            r = req0_ready;
            tick();
            if (r) begin idx++; nacc++; end
        end
        check32("t3_accepts",  nacc, 4);
        check1 ("t3_stalled",  req0_ready, 1'b0);
        check1 ("t3_rsp_vld",  rsp0_valid, 1'b1);
        check32("t3_head",     rsp0_y, 32'h3f800000);
        // req1 keeps working while req0 is out of credit
        req1_valid = 1'b1; req1_x1 = 32'h41800000; req1_x2 = 32'h40800000;
        #1;
        check1("t3_req1_ready", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        c = 1;
        while (!rsp1_valid && c < 30) begin
            tick(); c++;
        end
        check32("t3_req1_lat", c, 8);
        check32("t3_req1_y",   rsp1_y, 32'h40800000);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        check1("t3_req1_popped", rsp1_valid, 1'b0);
        // one pop buys exactly one more accept
        rsp0_ready = 1'b1;
        #1;
        check1("t3_no_comb_credit", req0_ready, 1'b0);
        tick();
        rsp0_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 14; i++) begin
            req0_valid = 1'b1;
            req0_x1 = t3[(idx < 5) ? idx : 4];
            #1;
            r = req0_ready;
            tick();
            if (r) begin idx++; nacc++; end
        end
        req0_valid = 1'b0;
        check32("t3_one_more", nacc, 1);
        k0 = 1;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rsp0_valid && k0 < 5) begin
                check32("t3_drain", rsp0_y, t3[k0]);
                k0++;
            end
            tick();
        end
        rsp0_ready = 1'b0;
        check32("t3_drained", k0, 5);

        // ---------------- req1 accept + pop in the same cycle ----------------
        idx = 0; nacc = 0;
        req1_x2 = 32'h3f800000;
        for (int i = 0; i < 12; i++) begin
            req1_valid = 1'b1;
            req1_x1 = t4[idx];
            #1;
            r = req1_ready;
            tick();
            if (r) begin idx++; nacc++; end
        end
        check32("t4_accepts", nacc, 4);
        check1 ("t4_full",    req1_ready, 1'b0);
        check32("t4_head",    rsp1_y, 32'h40400000);
        rsp1_ready = 1'b1;
        req1_x1 = t4[idx];
        #1;
        check1("t4_pop_not_comb", req1_ready, 1'b0);
        tick();                                   // pop 3.0: credit freed
        check1 ("t4_credit_back", req1_ready, 1'b1);
        check32("t4_head2",       rsp1_y, 32'h40a00000);
        tick();                                   // accept 11.0 and pop 5.0 together
        idx++;
        req1_x1 = t4[idx];
        rsp1_ready = 1'b0;
        #1;
        check1 ("t4_combined_keeps", req1_ready, 1'b1);
        check32("t4_head3",          rsp1_y, 32'h40e00000);
        tick();                                   // accept 13.0: back to full
        idx++;
        req1_x1 = t4[idx];
        #1;
        check1("t4_full_again", req1_ready, 1'b0);
        req1_valid = 1'b0;
        k1 = 2;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (rsp1_valid && k1 < 6) begin
                check32("t4_drain", rsp1_y, t4[k1]);
                k1++;
            end
            tick();
        end
        rsp1_ready = 1'b0;
        check32("t4_drained", k1, 6);

        // ---------------- reset with ops in flight ----------------
        req0_x1 = 32'h40400000; req0_x2 = 32'h3f800000;
        req0_valid = 1'b1;
        repeat (3) tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        check1 ("t5_div_valid",  div_valid,  1'b0);
        check32("t5_div_x1",     div_x1,     32'h0);
        check1 ("t5_req0_ready", req0_ready, 1'b0);
        check1 ("t5_req1_ready", req1_ready, 1'b0);
        check1 ("t5_rsp0_valid", rsp0_valid, 1'b0);
        check32("t5_rsp0_y",     rsp0_y,     32'h0);
        check32("t5_rsp1_y",     rsp1_y,     32'h0);
        rst = 1'b0;
        any_rsp = 1'b0; any_err = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            any_rsp = any_rsp | rsp0_valid | rsp1_valid;
            any_err = any_err | err_desync;
        end
        check1("t5_no_stray_rsp", any_rsp, 1'b0);
        check1("t5_no_stray_err", any_err, 1'b0);

        // ---------------- result with empty tag ----------------
        req0_x1 = 32'h40c00000; req0_x2 = 32'h40000000;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        c = 1;
        while (!rsp0_valid && c < 30) begin
            tick(); c++;
        end
        check32("t6_y",      rsp0_y, 32'h40400000);
        check1 ("t6_no_err", err_desync, 1'b0);
        div_out_valid = 1'b1;
        div_y = 32'hdeadbeef;
        tick();
        check1 ("t6_err",        err_desync, 1'b1);
        check32("t6_fifo_same",  rsp0_y,     32'h40400000);
        check1 ("t6_rsp1_none",  rsp1_valid, 1'b0);
        repeat (5) tick();
        check1("t6_sticky", err_desync, 1'b1);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check1("t6_no_extra", rsp0_valid, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check1("t6_err_cleared", err_desync, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
